mem_bus_target: RTL and testbench

- Memory-side responder for the CPU's byte-wide memory interface: answers CPU-initiated reads and writes.
- Reads are qualified by mem_cs/mem_oe; writes by mem_cs/mem_we.
- Holds an internal byte RAM mapped into a window of the 16-bit address space, with a programmable read wait-state count.
- Provides a side-band preload port so benches and boot logic can fill the RAM before the CPU runs.

---
 rtl/mem_bus_target.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_target.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_target.sv
// mem_bus_target: memory-side responder for the CPU byte-wide bus.
// Holds a 2^ADDR_W byte RAM mapped at BASE in the 16-bit address space.
// Reads are qualified by mem_cs/mem_oe and writes by mem_cs/mem_we.
// Read data appears READ_WAIT+1 cycles after the request is sampled.
// A side-band preload port fills the RAM independently of the bus.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   addr, data_in       CPU address and write data
//   data_out, data_oe   registered read data and its drive enable
//   mem_cs/oe/we        chip select, read strobe, write strobe
//   mem_ready           access complete (level for reads, pulse for writes)
//   proto_err           one-cycle pulse on an illegal strobe combination
//   load_en/addr/data   preload write port (bus write wins on a collision)
module mem_bus_target #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] BASE      = 16'h0000,
  parameter int          READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              data_oe,
  input  logic              mem_cs,
  input  logic              mem_oe,
  input  logic              mem_we,
  output logic              mem_ready,
  output logic              proto_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data
);

  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACK, WR_HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              mem_ready_q, mem_ready_d;
  logic              proto_err_q, proto_err_d;
  logic              we_prev_q, we_prev_d;

  logic [7:0]        ram [2**ADDR_W];

  logic              hit;
  logic [ADDR_W-1:0] offset;
  logic              bus_wr;

  // Next-state and next-output logic. Outputs default to idle values so
  // that anything other than an active drive or write acknowledge is quiet.
  always_comb begin
    hit         = mem_cs && (addr[15:ADDR_W] == BASE[15:ADDR_W]);
    offset      = addr[ADDR_W-1:0];
    state_d     = state_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    data_oe_d   = 1'b0;
    mem_ready_d = 1'b0;
    proto_err_d = 1'b0;
    we_prev_d   = mem_we;
    bus_wr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit && mem_oe && mem_we) begin
          proto_err_d = 1'b1;
        end else if (hit && mem_oe) begin
          off_d   = offset;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 4'd0) ? RD_DRIVE : RD_WAIT;
        end else if (hit && mem_we) begin
          // A reset on the same edge aborts the write before it commits.
          bus_wr      = !rst;
          mem_ready_d = 1'b1;
          state_d     = WR_ACK;
        end
      end

      RD_WAIT: begin
        if (!(mem_cs && mem_oe)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = RD_DRIVE;
        end
      end

      RD_DRIVE: begin
        // A write strobe rising during a read is flagged but otherwise ignored.
        if (hit && mem_oe && mem_we && !we_prev_q) proto_err_d = 1'b1;
        if (!(hit && mem_oe)) begin
          state_d = IDLE;
        end else if (offset != off_q) begin
          // New address under a held strobe: full re-latency from scratch.
          off_d   = offset;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_INIT == 4'd0) ? RD_DRIVE : RD_WAIT;
        end else begin
          // Re-reading every cycle lets a preload to this byte show through.
          data_out_d  = ram[off_q];
          data_oe_d   = 1'b1;
          mem_ready_d = 1'b1;
        end
      end

      WR_ACK: begin
        state_d = WR_HOLD;
      end

      WR_HOLD: begin
        if (!(mem_we && mem_cs)) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and output registers; RAM is deliberately outside this reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      off_q       <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      mem_ready_q <= 1'b0;
      proto_err_q <= 1'b0;
      we_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      mem_ready_q <= mem_ready_d;
      proto_err_q <= proto_err_d;
      we_prev_q   <= we_prev_d;
    end
  end

  // RAM write port. The bus write is issued last so it wins over a preload
  // to the same byte on the same edge.
  always_ff @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
    if (bus_wr)  ram[offset]    <= data_in;
  end

  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign mem_ready = mem_ready_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_bus_target.sv
// tb_mem_bus_target: two responders share one bus, one mapped at 0x0000 and
// one at 0xC000, both with 256 bytes and one read wait state.
module tb_mem_bus_target;

  localparam int RW = 1;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        mem_cs, mem_oe, mem_we;
  logic        load_en;
  logic [7:0]  load_addr, load_data;

  logic [7:0]  dout [2];
  logic        oe   [2];
  logic        rdy  [2];
  logic        perr [2];

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_target #(.ADDR_W(8), .BASE(16'h0000), .READ_WAIT(RW)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .data_out(dout[0]), .data_oe(oe[0]),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_ready(rdy[0]), .proto_err(perr[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  mem_bus_target #(.ADDR_W(8), .BASE(16'hC000), .READ_WAIT(RW)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .data_out(dout[1]), .data_oe(oe[1]),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_ready(rdy[1]), .proto_err(perr[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a read is answered once the same hit address has been
  // requested for 2+RW consecutive edges; a write happens on the first edge of
  // a write strobe; data comes from a byte array updated at each edge.
  int         run_len [2];
  logic [7:0] run_off [2];
  bit         wr_prev [2];
  logic [7:0] mdl     [2][256];
  bit         exp_oe  [2];
  bit         exp_rdy [2];
  bit         exp_perr[2];
  logic [7:0] exp_dout[2];
  bit         model_live = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] b_hi;
      bit h, rd, wr;
      b_hi = (k == 0) ? 8'h00 : 8'hC0;
      h    = mem_cs && (addr[15:8] == b_hi);
      wr   = 1'b0;
      if (rst) begin
        run_len[k]  = 0;
        wr_prev[k]  = 1'b0;
        exp_oe[k]   = 1'b0;
        exp_rdy[k]  = 1'b0;
        exp_perr[k] = 1'b0;
      end else begin
        exp_perr[k] = h && mem_oe && mem_we && run_len[k] == 0 && !wr_prev[k];
        wr = h && mem_we && !mem_oe && run_len[k] == 0 && !wr_prev[k];
        rd = h && mem_oe && !mem_we;
        if (rd && run_len[k] > 0 && addr[7:0] == run_off[k]) begin
          run_len[k]++;
        end else if (rd && !wr_prev[k]) begin
          run_len[k] = 1;
          run_off[k] = addr[7:0];
        end else begin
          run_len[k] = 0;
        end
        exp_oe[k]   = run_len[k] >= 2 + RW;
        exp_dout[k] = mdl[k][run_off[k]];
        exp_rdy[k]  = exp_oe[k] || wr;
        wr_prev[k]  = (wr || wr_prev[k]) && mem_cs && mem_we;
      end
      if (load_en) mdl[k][load_addr] = load_data;
      if (wr)      mdl[k][addr[7:0]] = data_in;
    end
    if (rst) model_live = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Per-cycle comparison against the model, half a cycle after each edge.
  always @(negedge clk) begin
    if (model_live) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput(k == 0 ? "oe0" : "oe1", {7'd0, oe[k]}, {7'd0, exp_oe[k]});
        checkOutput(k == 0 ? "rdy0" : "rdy1", {7'd0, rdy[k]}, {7'd0, exp_rdy[k]});
        checkOutput(k == 0 ? "perr0" : "perr1", {7'd0, perr[k]}, {7'd0, exp_perr[k]});
        if (exp_oe[k]) checkOutput(k == 0 ? "dout0" : "dout1", dout[k], exp_dout[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                               input logic [15:0] a, input logic [7:0] d);
    mem_cs  = cs;
    mem_oe  = rd;
    mem_we  = wr;
    addr    = a;
    data_in = d;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  task automatic wait_drive(input int k);
    for (int i = 0; i < 20; i++) begin
      if (oe[k]) break;
      step();
    end
    checkOutput("drive_timeout", {7'd0, oe[k]}, 8'd1);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step(); step();
    rst = 1'b0;

    // Reset in the middle of a read wait; RAM keeps its preload.
    preload(8'h00, 8'h3E);
    applyStimulus(1, 1, 0, 16'h0000, 8'h00);
    step();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step(); step();
    rst = 1'b0;
    checkOutput("rst_oe", {7'd0, oe[0]}, 8'd0);
    checkOutput("rst_rdy", {7'd0, rdy[0]}, 8'd0);
    step();

    // Basic read with one wait state.
    applyStimulus(1, 1, 0, 16'h0000, 8'h00);
    step();
    checkOutput("rd_n0_oe", {7'd0, oe[0]}, 8'd0);
    step();
    checkOutput("rd_n1_oe", {7'd0, oe[0]}, 8'd0);
    step();
    checkOutput("rd_n2_oe", {7'd0, oe[0]}, 8'd1);
    checkOutput("rd_n2_data", dout[0], 8'h3E);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step();
    checkOutput("rd_drop_oe", {7'd0, oe[0]}, 8'd0);

    // Write held four cycles: one acknowledge, one write.
    applyStimulus(1, 0, 1, 16'h0012, 8'hA5);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rdy[0]) cnt++;
    end
    checkOutput("wr_ready_count", 8'(cnt), 8'd1);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step(); step();
    applyStimulus(1, 1, 0, 16'h0012, 8'h00);
    wait_drive(0);
    checkOutput("raw_data", dout[0], 8'hA5);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step();

    // Window boundaries on the 0xC000 instance.
    preload(8'hFF, 8'h77);
    applyStimulus(1, 1, 0, 16'hC0FF, 8'h00);
    wait_drive(1);
    checkOutput("top_data", dout[1], 8'h77);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step();
    applyStimulus(1, 1, 0, 16'hC100, 8'h00);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (oe[1] || rdy[1]) cnt++;
    end
    checkOutput("miss_above", 8'(cnt), 8'd0);
    applyStimulus(1, 1, 0, 16'hBFFF, 8'h00);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (oe[1] || rdy[1]) cnt++;
    end
    checkOutput("miss_below", 8'(cnt), 8'd0);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step();

    // Address change during a driven read restarts the latency.
    preload(8'h01, 8'h41);
    preload(8'h02, 8'h42);
    applyStimulus(1, 1, 0, 16'h0001, 8'h00);
    wait_drive(0);
    checkOutput("chg_first", dout[0], 8'h41);
    applyStimulus(1, 1, 0, 16'h0002, 8'h00);
    step();
    checkOutput("chg_gap0", {7'd0, oe[0]}, 8'd0);
    step();
    checkOutput("chg_gap1", {7'd0, oe[0]}, 8'd0);
    step();
    checkOutput("chg_oe", {7'd0, oe[0]}, 8'd1);
    checkOutput("chg_data", dout[0], 8'h42);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step();

    // Illegal strobes leave RAM untouched.
    preload(8'h05, 8'h99);
    applyStimulus(1, 1, 1, 16'h0005, 8'h55);
    step();
    checkOutput("perr_pulse", {7'd0, perr[0]}, 8'd1);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step();
    checkOutput("perr_end", {7'd0, perr[0]}, 8'd0);
    applyStimulus(1, 1, 0, 16'h0005, 8'h00);
    wait_drive(0);
    checkOutput("perr_ram", dout[0], 8'h99);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step();

    // Same-edge preload and bus write: the bus write wins.
    load_en = 1'b1; load_addr = 8'h05; load_data = 8'h11;
    applyStimulus(1, 0, 1, 16'h0005, 8'h22);
    step();
    load_en = 1'b0;
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step(); step();
    applyStimulus(1, 1, 0, 16'h0005, 8'h00);
    wait_drive(0);
    checkOutput("contend_data", dout[0], 8'h22);

    // Preload to the byte being driven shows up one cycle later.
    load_en = 1'b1; load_addr = 8'h05; load_data = 8'h33;
    step();
    load_en = 1'b0;
    checkOutput("pl_old", dout[0], 8'h22);
    step();
    checkOutput("pl_new", dout[0], 8'h33);
    applyStimulus(0, 0, 0, 16'h0000, 8'h00);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
